// File: rtl/game_pkg.sv
// Shared types and default timing constants for the MazeRunner game sequencer.
package game_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      BANNER   = 3'd1,
      PLAY     = 3'd2,
      CLEAR    = 3'd3,
      WIN      = 3'd4,
      GAMEOVER = 3'd5
   } phase_t;

   localparam int DEF_NUM_LEVELS    = 2;
   localparam int DEF_BANNER_FRAMES = 120;
   localparam int DEF_END_FRAMES    = 300;
   localparam int BLINK_PERIOD      = 32;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Game-flow signal bundle: control inputs and text bits in, phase/level/overlay out.
interface game_flow_ctrl_if #(
   parameter int LVL_W = 2
);
   logic             frame_tick;
   logic             start_btn;
   logic             goal_reached;
   logic             player_dead;
   logic             game_over_text;
   logic             win_text;
   logic             level_text;
   logic             level_num1_text;
   logic             level_num2_text;
   logic [LVL_W-1:0] level;
   logic             game_active;
   logic             load_level;
   logic             text_pixel;
   logic [2:0]       phase;

   modport master (
      output frame_tick, start_btn, goal_reached, player_dead,
             game_over_text, win_text, level_text, level_num1_text, level_num2_text,
      input  level, game_active, load_level, text_pixel, phase
   );

   modport slave (
      input  frame_tick, start_btn, goal_reached, player_dead,
             game_over_text, win_text, level_text, level_num1_text, level_num2_text,
      output level, game_active, load_level, text_pixel, phase
   );
endinterface

// File: rtl/game_flow_ctrl_frame_timer.sv
// Frame counter for timed screens: tc fires on the tick that completes limit frames,
// done holds once the count has saturated at limit.
module frame_timer #(
   parameter int CNT_W = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             frame_tick,
   input  logic [CNT_W-1:0] limit,
   output logic             tc,
   output logic             done
);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en && frame_tick && (cnt_q != limit))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign tc   = en && frame_tick && (cnt_q == limit - CNT_W'(1));
   assign done = (cnt_q == limit);
endmodule

// File: rtl/game_flow_ctrl.sv
// MazeRunner screen sequencer and overlay text mux.
// Optional: define BLINK_TEXT_EN to blink the WIN / GAME OVER text every BLINK_PERIOD frames.
module game_flow_ctrl
   import game_pkg::*;
#(
   parameter int NUM_LEVELS    = DEF_NUM_LEVELS,
   parameter int BANNER_FRAMES = DEF_BANNER_FRAMES,
   parameter int END_FRAMES    = DEF_END_FRAMES,
   parameter int LVL_W         = 2
) (
   input logic clk,
   input logic rst,
   game_flow_ctrl_if.slave bus
);
   localparam int CNT_W = $clog2(max_int(BANNER_FRAMES, END_FRAMES) + 1);
   localparam logic [CNT_W-1:0] BANNER_LIM = CNT_W'(BANNER_FRAMES);
   localparam logic [CNT_W-1:0] END_LIM    = CNT_W'(END_FRAMES);
   localparam logic [LVL_W-1:0] LAST_LEVEL = LVL_W'(NUM_LEVELS - 1);

   phase_t           state_q, state_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             game_active_q, game_active_d;
   logic             load_level_q, load_level_d;
   logic             text_pixel_q, text_pixel_d;
   logic             cnt_clr, cnt_en, cnt_tc, cnt_done;
   logic [CNT_W-1:0] cnt_lim;
   logic             end_gate;

   frame_timer #(.CNT_W(CNT_W)) u_frame_timer (
      .clk        (clk),
      .rst        (rst),
      .clr        (cnt_clr),
      .en         (cnt_en),
      .frame_tick (bus.frame_tick),
      .limit      (cnt_lim),
      .tc         (cnt_tc),
      .done       (cnt_done)
   );

   always_comb begin
      state_d       = state_q;
      level_d       = level_q;
      load_level_d  = 1'b0;
      cnt_clr       = 1'b0;
      cnt_en        = 1'b0;
      cnt_lim       = BANNER_LIM;
      text_pixel_d  = 1'b0;
      case (state_q)
         IDLE: if (bus.start_btn) begin
            state_d      = BANNER;
            level_d      = '0;
            load_level_d = 1'b1;
            cnt_clr      = 1'b1;
         end
         BANNER: begin
            cnt_en       = 1'b1;
            text_pixel_d = bus.level_text |
                           ((level_q == '0) ? bus.level_num1_text : bus.level_num2_text);
            if (cnt_tc) begin
               state_d = PLAY;
               cnt_clr = 1'b1;
            end
         end
         PLAY: begin
            // Death wins over a simultaneous goal so a fatal step never counts as a win.
            if (bus.player_dead) begin
               state_d = GAMEOVER;
               cnt_clr = 1'b1;
            end else if (bus.goal_reached) begin
               state_d = (level_q == LAST_LEVEL) ? WIN : CLEAR;
               cnt_clr = 1'b1;
            end
         end
         CLEAR: begin
            state_d      = BANNER;
            level_d      = level_q + LVL_W'(1);
            load_level_d = 1'b1;
            cnt_clr      = 1'b1;
         end
         WIN, GAMEOVER: begin
            cnt_en       = 1'b1;
            cnt_lim      = END_LIM;
            text_pixel_d = ((state_q == WIN) ? bus.win_text : bus.game_over_text) & end_gate;
            if (cnt_done && bus.start_btn) begin
               state_d = IDLE;
               cnt_clr = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      game_active_d = (state_d == PLAY);
   end

`ifdef BLINK_TEXT_EN
   localparam int BLINK_W = $clog2(BLINK_PERIOD);
   logic               blink_q, blink_d;
   logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic               in_end, enter_end;

   always_comb begin
      in_end      = (state_q == WIN) || (state_q == GAMEOVER);
      enter_end   = ((state_d == WIN) || (state_d == GAMEOVER)) && !in_end;
      blink_d     = blink_q;
      blink_cnt_d = blink_cnt_q;
      if (enter_end) begin
         blink_d     = 1'b1;
         blink_cnt_d = '0;
      end else if (in_end && bus.frame_tick) begin
         blink_cnt_d = blink_cnt_q + BLINK_W'(1);
         if (blink_cnt_q == BLINK_W'(BLINK_PERIOD - 1))
            blink_d = ~blink_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         blink_q     <= 1'b1;
         blink_cnt_q <= '0;
      end else begin
         blink_q     <= blink_d;
         blink_cnt_q <= blink_cnt_d;
      end
   end

   assign end_gate = blink_q;
`else
   assign end_gate = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         level_q       <= '0;
         game_active_q <= 1'b0;
         load_level_q  <= 1'b0;
         text_pixel_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         level_q       <= level_d;
         game_active_q <= game_active_d;
         load_level_q  <= load_level_d;
         text_pixel_q  <= text_pixel_d;
      end
   end

   assign bus.level       = level_q;
   assign bus.game_active = game_active_q;
   assign bus.load_level  = load_level_q;
   assign bus.text_pixel  = text_pixel_q;
   assign bus.phase       = state_q;
endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Top-level game sequencer for MazeRunner. It decides which screen phase is active: level banner, play, win or game over. It counts frames for timed screens and tracks the current level. It also gates and muxes the overlay pixel bits produced by the text renderer into a single text_pixel for the VGA colour mux.

Parameters:
NUM_LEVELS, 2, number of mazes; the level index runs 0..NUM_LEVELS-1.
BANNER_FRAMES, 120, frames the "LEVEL n" banner is shown before play starts.
END_FRAMES, 300, frames the WIN / GAME OVER screen is held before start_btn is accepted.
LVL_W, 2, width of the level index; must satisfy 2^LVL_W >= NUM_LEVELS.

Ports:
clk  in  1  pixel clock
rst  in  1  reset, synchronous, active-high
frame_tick  in  1  one-cycle pulse per frame (start of vertical blank)
start_btn  in  1  debounced, level-sensitive start/restart request
goal_reached  in  1  player is on the exit tile (level)
player_dead  in  1  collision or timeout (level)
game_over_text  in  1  pixel bit from the text renderer
win_text  in  1  pixel bit from the text renderer
level_text  in  1  pixel bit from the text renderer
level_num1_text  in  1  pixel bit from the text renderer
level_num2_text  in  1  pixel bit from the text renderer
level  out  LVL_W  current level index
game_active  out  1  high only in PLAY; enables player movement and the timer
load_level  out  1  one-cycle pulse telling the maze and player logic to reload positions for level
text_pixel  out  1  registered overlay pixel
phase  out  3  encoded state, for debug and LEDs

Behaviour:
- States: IDLE, BANNER, PLAY, CLEAR, WIN, GAMEOVER. Encoding lives in the package.
- Reset values: state=IDLE; level=0; frame_cnt=0; game_active=0; load_level=0; text_pixel=0. Reset has the same effect at any point, mid-screen included.
- IDLE: shows no text.
  - start_btn=1 -> BANNER, level=0, load_level pulses in the same transition cycle, frame_cnt cleared.
- BANNER: frame_cnt increments on each frame_tick.
  - When frame_tick arrives with frame_cnt==BANNER_FRAMES-1 -> PLAY, frame_cnt cleared.
- PLAY: game_active=1.
  - If player_dead=1 -> GAMEOVER. player_dead has priority when both inputs rise in the same cycle.
  - Otherwise, if goal_reached=1 and level==NUM_LEVELS-1 -> WIN.
  - Otherwise, if goal_reached=1 -> CLEAR.
- CLEAR: lasts exactly 1 cycle. level increments, load_level pulses, frame_cnt cleared, -> BANNER.
- WIN and GAMEOVER: frame_cnt counts frame_ticks and saturates at END_FRAMES.
  - Once saturated, start_btn=1 -> IDLE. start_btn is ignored before saturation, so a button held from play cannot skip the screen.
- game_active is registered and equals (next state == PLAY); it drops the cycle the FSM leaves PLAY.
- text_pixel has 1-cycle latency, registered from the current state:
  - BANNER: level_text | (level==0 ? level_num1_text : level_num2_text)
  - WIN: win_text
  - GAMEOVER: game_over_text
  - any other state: 0
- frame_cnt width is clog2(max(BANNER_FRAMES, END_FRAMES)+1). It never wraps.
- frame_tick outside BANNER, WIN and GAMEOVER is ignored.
- Level numbers beyond 2 reuse level_num2_text; the renderer only supplies glyphs for levels 1 and 2.

Optional Feature:
BLINK_TEXT_EN
- Defined: in WIN and GAMEOVER, text_pixel is additionally ANDed with blink, a bit that toggles every 32 frame_ticks. blink resets to 1 and is forced to 1 on entry to those states.
- Undefined: end-screen text is steady; no blink register exists.

Decomposition:
- Package game_pkg holds:
  - the phase_t enum (IDLE=0, BANNER=1, PLAY=2, CLEAR=3, WIN=4, GAMEOVER=5)
  - NUM_LEVELS and the frame-count defaults
  - the blink period constant
- One natural sub-module: frame_timer (clear, enable, frame_tick, terminal count, saturating done flag), instantiated once.
- The FSM and the text mux stay in game_flow_ctrl.

Test Plan:
- Bench configuration: BANNER_FRAMES=3, END_FRAMES=4, NUM_LEVELS=2 unless noted.
- Reset, then start_btn pulse -> phase=BANNER, load_level=1 for exactly 1 cycle, level=0; 3 frame_ticks -> phase=PLAY, game_active=1 the next cycle.
- In PLAY, level 0, goal_reached=1 -> CLEAR for 1 cycle, level=1, load_level pulse, BANNER; with level_num2_text=1 -> text_pixel=1 one cycle later.
- In PLAY, level 1, goal_reached=1 and player_dead=1 in the same cycle -> GAMEOVER, not WIN; game_active=0.
- In GAMEOVER, hold start_btn=1 -> stays in GAMEOVER for 4 frame_ticks, then IDLE on the next cycle; text_pixel follows game_over_text with 1-cycle delay.
- rst=1 asserted mid-BANNER with frame_cnt=2 -> next cycle phase=IDLE, level=0, text_pixel=0; one extra frame_tick produces no transition.
- With BLINK_TEXT_EN defined and win_text=1 held in WIN -> text_pixel=1 for 32 frame_ticks, then 0 for the next 32.
